// File: rtl/pixel_pkg.sv
// Shared pixel type and feeder FSM states for the edge-detection front end.
package pixel_pkg;
  localparam int PIX_W = 5;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;
endpackage

// File: rtl/line_shift_buffer.sv
// One image row of delay: dout is the pixel accepted exactly DEPTH enables ago.
// No reset on storage; no latency beyond the shift itself; holds when en is low.
module line_shift_buffer
  import pixel_pkg::*;
#(
  parameter int DEPTH = 102
) (
  input  logic   clk,
  input  logic   en,
  input  pixel_t din,
  output pixel_t dout
);

  pixel_t sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      sr_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/pixel_window_feeder.sv
// Turns a raster pixel stream into 5-row vertical columns; 1-cycle latency.
// No backpressure: in_valid low stalls everything and the column outputs hold.
module pixel_window_feeder
  import pixel_pkg::*;
#(
  parameter int COLS = 102,
  parameter int ROWS = 102
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  pixel_t in_pixel,
  output pixel_t pixel_out0,
  output pixel_t pixel_out1,
  output pixel_t pixel_out2,
  output pixel_t pixel_out3,
  output pixel_t pixel_out4,
  output logic   out_valid,
  output logic   load_end
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] FILL_LAST = ROW_W'(3);

  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  state_e           state_q, state_d;
  pixel_t           col_q [5];
  pixel_t           col_d [5];
  logic             out_valid_q, out_valid_d;
  logic             load_end_q, load_end_d;

  pixel_t tail0, tail1, tail2, tail3;
  logic   col_wrap, row_wrap;

  // Chain: in_pixel -> lb3 -> lb2 -> lb1 -> lb0, each tail one row older.
  line_shift_buffer #(.DEPTH(COLS)) u_lb3 (.clk(clk), .en(in_valid), .din(in_pixel), .dout(tail3));
  line_shift_buffer #(.DEPTH(COLS)) u_lb2 (.clk(clk), .en(in_valid), .din(tail3),    .dout(tail2));
  line_shift_buffer #(.DEPTH(COLS)) u_lb1 (.clk(clk), .en(in_valid), .din(tail2),    .dout(tail1));
  line_shift_buffer #(.DEPTH(COLS)) u_lb0 (.clk(clk), .en(in_valid), .din(tail1),    .dout(tail0));

  assign col_wrap = (col_cnt_q == COL_LAST);
  assign row_wrap = (row_cnt_q == ROW_LAST);

  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    state_d     = state_q;
    col_d       = col_q;
    out_valid_d = 1'b0;
    load_end_d  = 1'b0;
    if (in_valid) begin
      col_cnt_d = col_wrap ? '0 : col_cnt_q + 1'b1;
      if (col_wrap) begin
        row_cnt_d = row_wrap ? '0 : row_cnt_q + 1'b1;
      end
      case (state_q)
        FILL: begin
          if (col_wrap && (row_cnt_q == FILL_LAST)) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          col_d       = '{tail0, tail1, tail2, tail3, in_pixel};
          out_valid_d = 1'b1;
          load_end_d  = col_wrap && row_wrap;
          if (col_wrap && row_wrap) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      state_q     <= FILL;
      col_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      load_end_q  <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      state_q     <= state_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      load_end_q  <= load_end_d;
    end
  end

  assign pixel_out0 = col_q[0];
  assign pixel_out1 = col_q[1];
  assign pixel_out2 = col_q[2];
  assign pixel_out3 = col_q[3];
  assign pixel_out4 = col_q[4];
  assign out_valid  = out_valid_q;
  assign load_end   = load_end_q;

endmodule

// File: tb/tb_pixel_window_feeder.sv
// Directed bench for pixel_window_feeder at COLS=4, ROWS=6 with an image-history scoreboard.
module tb_pixel_window_feeder;

  localparam int COLS = 4;
  localparam int ROWS = 6;

  typedef struct packed {
    logic [24:0] pix;
    logic        le;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [4:0] in_pixel;
  logic [4:0] pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4;
  logic       out_valid;
  logic       load_end;
  logic [24:0] dut_col;

  int   n_assert;
  int   n_fail;
  exp_t sb [$];
  logic [4:0] img [ROWS][COLS];
  int   r_m, c_m;
  logic mon_en;
  logic [24:0] last_pix;
  int   dut_vld_cnt;

  pixel_window_feeder #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .pixel_out0(pixel_out0),
    .pixel_out1(pixel_out1),
    .pixel_out2(pixel_out2),
    .pixel_out3(pixel_out3),
    .pixel_out4(pixel_out4),
    .out_valid (out_valid),
    .load_end  (load_end)
  );

  assign dut_col = {pixel_out0, pixel_out1, pixel_out2, pixel_out3, pixel_out4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; the expected column is queued after capture.
  task automatic send(input logic v, input logic [4:0] pix);
    exp_t e;
    in_valid = v;
    in_pixel = pix;
    @(posedge clk);
    #1;
    if (v) begin
      img[r_m][c_m] = pix;
      if (r_m >= 4) begin
        e.pix = {img[r_m-4][c_m], img[r_m-3][c_m], img[r_m-2][c_m], img[r_m-1][c_m], pix};
        e.le  = (r_m == ROWS - 1) && (c_m == COLS - 1);
        sb.push_back(e);
      end
      if (c_m == COLS - 1) begin
        c_m = 0;
        r_m = (r_m == ROWS - 1) ? 0 : r_m + 1;
      end else begin
        c_m = c_m + 1;
      end
    end
  endtask

  task automatic send_frame(input int off, input bit do_stall);
    logic [24:0] exp_col;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (do_stall && r == 4 && c == 2) begin
          repeat (3) send(1'b0, 5'($urandom_range(0, 31)));
        end
        send(1'b1, 5'((4 * r + c + off) % 32));
        if (r == 4 && c == 0) begin
          exp_col = {5'(off), 5'(4 + off), 5'(8 + off), 5'(12 + off), 5'(16 + off)};
          chk("first_col", dut_col, exp_col);
          chk("first_col_le", load_end, 0);
        end
        if (do_stall && r == 4 && c == 2) begin
          exp_col = {5'(2 + off), 5'(6 + off), 5'(10 + off), 5'(14 + off), 5'(18 + off)};
          chk("resume_col", dut_col, exp_col);
        end
        if (r == ROWS - 1 && c == COLS - 1) begin
          exp_col = {5'(7 + off), 5'(11 + off), 5'(15 + off), 5'(19 + off), 5'(23 + off)};
          chk("end_col", dut_col, exp_col);
          chk("end_le", load_end, 1);
        end
      end
    end
  endtask

  // Every cycle: out_valid must match scoreboard occupancy; idle cycles must hold the last column.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      last_pix    = '0;
      dut_vld_cnt = 0;
    end else if (mon_en) begin
      chk("out_valid", out_valid, (sb.size() != 0));
      if (out_valid === 1'b1) dut_vld_cnt++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("col", dut_col, e.pix);
        chk("load_end", load_end, e.le);
        last_pix = e.pix;
      end else begin
        chk("hold_col", dut_col, last_pix);
        chk("idle_le", load_end, 0);
      end
      if (load_end === 1'b1) begin
        chk("frame_vld_cycles", dut_vld_cnt, (ROWS - 4) * COLS);
        dut_vld_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    last_pix    = '0;
    dut_vld_cnt = 0;
    r_m         = 0;
    c_m         = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_pixel    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", dut_col, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_le", load_end, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    send(1'b0, 5'd0);

    // Frame A with a 3-cycle stall in row 4, then frame B back-to-back with +1 offset.
    send_frame(0, 1'b1);
    send_frame(1, 1'b0);
    send(1'b0, 5'd0);

    // Frame C aborted by reset while pixel (4,1) is presented.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < COLS; c++) begin
        send(1'b1, 5'((4 * r + c + 2) % 32));
      end
    end
    send(1'b1, 5'd18);
    chk("pre_rst_vld", out_valid, 1);
    in_valid = 1'b1;
    in_pixel = 5'd19;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_col", dut_col, 0);
    chk("async_rst_vld", out_valid, 0);
    chk("async_rst_le", load_end, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    r_m      = 0;
    c_m      = 0;

    // Frame D must restart cleanly at (0,0).
    send(1'b0, 5'd0);
    send_frame(3, 1'b0);
    send(1'b0, 5'd0);
    send(1'b0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_window_feeder.md
# pixel_window_feeder

Upstream feeder for the edge-detection CHIP. It takes a raster-order stream of 5-bit pixels, one per cycle, and buffers four previous image rows. It then emits vertically aligned 5-pixel columns on `pixel_out0..4`, which connect directly to the CHIP's `pixel_in0..4`. It asserts `load_end` with the final column of each frame, so the CHIP knows the frame is complete.

## Interface
- `COLS`, default 102: pixels per image row (100 plus 2 padding columns); must be ≥ 2.
- `ROWS`, default 102: rows per frame (100 plus 2 padding rows); must be ≥ 5.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all control state and outputs.
- `in_valid` input, 1 bit: `in_pixel` holds a valid raster pixel this cycle.
- `in_pixel` input, 5 bits: incoming pixel, row-major order, column 0 first.
- `pixel_out0` output, 5 bits: pixel from row r-4 (oldest).
- `pixel_out1` output, 5 bits: pixel from row r-3.
- `pixel_out2` output, 5 bits: pixel from row r-2.
- `pixel_out3` output, 5 bits: pixel from row r-1.
- `pixel_out4` output, 5 bits: pixel from row r (the current input).
- `out_valid` output, 1 bit: the `pixel_out*` outputs hold a valid column.
- `load_end` output, 1 bit: asserted with `out_valid` on the last column of the frame.

## Operation
- **Line buffers.** Four COLS-deep, 5-bit shift registers are chained: `in_pixel` → lb3 → lb2 → lb1 → lb0.
  - All four shift only on `in_valid`.
  - The tail of each buffer is the pixel exactly COLS accepted pixels earlier, i.e. the same column one row up.
- **Counters.**
  - `col_cnt` covers 0..COLS-1 and is $clog2(COLS) bits wide. It increments on each accepted pixel and wraps to 0 after COLS-1.
  - `row_cnt` covers 0..ROWS-1 and is $clog2(ROWS) bits wide. It increments when `col_cnt` wraps, and wraps to 0 after ROWS-1.
- **FSM states.**
  - FILL: `row_cnt` < 4. Pixels are shifted in and no output is produced. FILL → STREAM on the pixel that completes row 3.
  - STREAM: `row_cnt` ≥ 4. Every accepted pixel produces one output column. STREAM → FILL on the pixel at (ROWS-1, COLS-1), which is also the `load_end` pixel.
- **Output column.** For an accepted pixel at (r, c) in STREAM, the next cycle shows:
  - `pixel_out4` = `in_pixel`
  - `pixel_out3` = lb3 tail
  - `pixel_out2` = lb2 tail
  - `pixel_out1` = lb1 tail
  - `pixel_out0` = lb0 tail
  - `out_valid` = 1
  - `load_end` = 1 only when r = ROWS-1 and c = COLS-1
- **Stall.** When `in_valid` = 0, no shift and no counter change occur. Next cycle `out_valid` = 0 and `load_end` = 0, and the `pixel_out*` values hold their previous values.
- **Frame-to-frame.** The buffers are not cleared between frames; the FILL phase overwrites stale rows before any of them reach an output. The first pixel of the next frame may arrive in the cycle immediately after the `load_end` pixel.
- **Arithmetic.** The block only passes pixels through; no arithmetic on pixel data and no saturation.

## Timing
- Latency is 1 cycle from the accepted pixel to its registered output column.
- Throughput is 1 column per cycle in STREAM.
- Output columns per frame = (ROWS-4)·COLS.
- `load_end` is a single-cycle pulse per frame, always coincident with `out_valid`.
- Reset values:
  - `pixel_out0..4` = 0
  - `out_valid` = 0
  - `load_end` = 0
  - `col_cnt` = 0 and `row_cnt` = 0
  - FSM in FILL
- Line-buffer contents have no reset.
- Reset mid-frame: outputs clear immediately (asynchronously). The next accepted pixel is treated as (0, 0) of a new frame.
- `reset` and `in_valid` high in the same cycle: reset wins and the pixel is dropped.

## Structure
- Shared package `pixel_pkg` holds:
  - `PIX_W` = 5
  - `typedef logic [PIX_W-1:0] pixel_t`
  - the FSM state enum {FILL, STREAM}
- Sub-module `line_shift_buffer`:
  - Parameters: DEPTH, width `pixel_t`.
  - Ports: `clk`, `en`, `din`, `dout` (tail).
  - Instantiated 4 times.
- Counters, FSM and output registers live in the top level.

## Test plan
All scenarios use COLS=4, ROWS=6 and input value = (4·r + c) mod 32.
- **Fill suppression.** Stream rows 0–3 continuously → `out_valid` stays 0 for all 16 cycles.
- **First column.** Row 4, col 0 (input 16) → next cycle `pixel_out0..4` = 0, 4, 8, 12, 16; `out_valid`=1; `load_end`=0.
- **Frame end.** Row 5, col 3 (input 23) → outputs 7, 11, 15, 19, 23 with `load_end`=1. Exactly 8 `out_valid` cycles in total for the frame.
- **Stall.** Drop `in_valid` for 3 cycles in the middle of row 4 → `out_valid`=0 for 3 cycles and outputs hold. Resumed columns are still correct (col 2 gives 2, 6, 10, 14, 18).
- **Back-to-back frames.** Send a second frame immediately after `load_end`, with values offset by +1 → no output during its rows 0–3. Its row 4, col 0 gives 1, 5, 9, 13, 17.
- **Reset mid-frame.** Pulse `reset` during row 4, col 1 → outputs go to 0 at once. The following 16 pixels produce no `out_valid`, and the next frame decodes correctly.
